// File: rtl/fosfor_present_top.sv
// PRESENT-80 block cipher behind a nibble-wide pad bus (8 bits in, 8 bits out).
// Latency: one round per clock, ready returns 32 cycles after the START edge; io_out is registered.
// Backpressure: none, the host polls the ready bit; while busy, START and state/key writes are dropped.
// Build option: define FOSFOR_TEST_REG_EN to map an 8-bit scratch register at address 0x08.
module fosfor_present_top (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  // Pad breakout
  logic       Clk_k;
  logic       Reset_r;
  logic [1:0] address_b;
  logic [3:0] data_in_b;

  assign Clk_k     = io_in[0];
  assign Reset_r   = io_in[1];
  assign address_b = io_in[3:2];
  assign data_in_b = io_in[7:4];

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_t;

  localparam logic [1:0] BUS_CMD   = 2'b01;
  localparam logic [1:0] BUS_LOW   = 2'b10;
  localparam logic [1:0] BUS_HIGH  = 2'b11;
  localparam logic [3:0] CMD_LATCH = 4'b0001;
  localparam logic [3:0] CMD_READ  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_START = 4'b1000;
  localparam logic [5:0] RC_LAST   = 6'd32;

  fsm_t        fsm_q, fsm_d;
  logic [7:0]  data_reg_q, data_reg_d;
  logic [7:0]  addr_reg_q, addr_reg_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  out_q, out_d;
  logic        show_data_q, show_data_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [79:0] wkey_q, wkey_d;
  logic [5:0]  rc_q, rc_d;
  logic [7:0]  rd_dat;
  logic        addr_is_state;
  logic        addr_is_key;
`ifdef FOSFOR_TEST_REG_EN
  logic [7:0]  test_reg_q, test_reg_d;
`endif

  // PRESENT 4-bit S-box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[6'(4 * i) +: 4] = sbox(x[6'(4 * i) +: 4]);
    end
    return r;
  endfunction

  // Bit i moves to bit 16*i mod 63; bit 63 stays in place
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[6'((16 * i) % 63)] = x[6'(i)];
    end
    r[63] = x[63];
    return r;
  endfunction

  // Key schedule step: rotate left 61, S-box the top nibble, fold in the round counter
  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  assign addr_is_state = (addr_reg_q[7:3] == 5'b00000);
  assign addr_is_key   = (addr_reg_q >= 8'h10) && (addr_reg_q <= 8'h19);

  // Memory-map read mux; unmapped addresses read zero
  always_comb begin
    rd_dat = 8'h00;
    if (addr_is_state) begin
      rd_dat = state_q[{addr_reg_q[2:0], 3'b000} +: 8];
    end else if (addr_is_key) begin
      rd_dat = key_q[{addr_reg_q[3:0], 3'b000} +: 8];
    end
`ifdef FOSFOR_TEST_REG_EN
    else if (addr_reg_q == 8'h08) begin
      rd_dat = test_reg_q;
    end
`endif
  end

  // Bus decode, command execution and one cipher round per cycle while running
  always_comb begin
    fsm_d       = fsm_q;
    data_reg_d  = data_reg_q;
    addr_reg_d  = addr_reg_q;
    rbuf_d      = rbuf_q;
    show_data_d = show_data_q;
    state_d     = state_q;
    key_d       = key_q;
    wkey_d      = wkey_q;
    rc_d        = rc_q;
`ifdef FOSFOR_TEST_REG_EN
    test_reg_d  = test_reg_q;
`endif

    case (address_b)
      BUS_LOW:  data_reg_d[3:0] = data_in_b;
      BUS_HIGH: data_reg_d[7:4] = data_in_b;
      BUS_CMD: begin
        case (data_in_b)
          CMD_LATCH: begin
            addr_reg_d  = data_reg_q;
            show_data_d = 1'b0;
          end
          CMD_READ: begin
            rbuf_d      = rd_dat;
            show_data_d = 1'b1;
          end
          CMD_WRITE: begin
            show_data_d = 1'b0;
            // Cipher registers are frozen while a block is in flight
            if (fsm_q == ST_IDLE) begin
              if (addr_is_state) begin
                state_d[{addr_reg_q[2:0], 3'b000} +: 8] = data_reg_q;
              end else if (addr_is_key) begin
                key_d[{addr_reg_q[3:0], 3'b000} +: 8] = data_reg_q;
              end
            end
`ifdef FOSFOR_TEST_REG_EN
            if (addr_reg_q == 8'h08) begin
              test_reg_d = data_reg_q;
            end
`endif
          end
          CMD_START: begin
            show_data_d = 1'b0;
            if (fsm_q == ST_IDLE) begin
              fsm_d  = ST_RUN;
              wkey_d = key_q;
              rc_d   = 6'd1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    if (fsm_q == ST_RUN) begin
      if (rc_q == RC_LAST) begin
        // Post-whitening with the 32nd round key
        state_d = state_q ^ wkey_q[79:16];
        fsm_d   = ST_IDLE;
      end else begin
        state_d = p_layer(s_layer(state_q ^ wkey_q[79:16]));
        wkey_d  = key_update(wkey_q, rc_q[4:0]);
        rc_d    = rc_q + 6'd1;
      end
    end

    // Output byte follows the next-state values so it is valid right after each edge
    out_d = show_data_d ? rbuf_d : {7'b0000000, (fsm_d == ST_IDLE)};
  end

  // State registers, cleared asynchronously
  always_ff @(posedge Clk_k or negedge Reset_r) begin
    if (!Reset_r) begin
      fsm_q       <= ST_IDLE;
      data_reg_q  <= 8'h00;
      addr_reg_q  <= 8'h00;
      rbuf_q      <= 8'h00;
      out_q       <= 8'h01;
      show_data_q <= 1'b0;
      state_q     <= 64'h0;
      key_q       <= 80'h0;
      wkey_q      <= 80'h0;
      rc_q        <= 6'd0;
`ifdef FOSFOR_TEST_REG_EN
      test_reg_q  <= 8'h00;
`endif
    end else begin
      fsm_q       <= fsm_d;
      data_reg_q  <= data_reg_d;
      addr_reg_q  <= addr_reg_d;
      rbuf_q      <= rbuf_d;
      out_q       <= out_d;
      show_data_q <= show_data_d;
      state_q     <= state_d;
      key_q       <= key_d;
      wkey_q      <= wkey_d;
      rc_q        <= rc_d;
`ifdef FOSFOR_TEST_REG_EN
      test_reg_q  <= test_reg_d;
`endif
    end
  end

  assign io_out = out_q;

endmodule

// File: tb/tb_fosfor_present_top.sv
// Bench for fosfor_present_top: directed PRESENT-80 vectors over the nibble bus.
// Expected io_out bytes are queued with the cycle they are due; a negedge monitor checks them.
module tb_fosfor_present_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] addr_b = 2'b00;
  logic [3:0] din_b = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {din_b, addr_b, rst_n, clk};

  fosfor_present_top dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] A_IDLE = 2'b00, A_CMD = 2'b01, A_LOW = 2'b10, A_HIGH = 2'b11;
  localparam logic [3:0] C_LATCH = 4'b0001, C_READ = 4'b0010, C_WRITE = 4'b0100, C_START = 4'b1000;

  int cyc = 0;
  int drv_cyc = 0;
  int checks = 0;
  int errors = 0;

  int         q_cyc[$];
  logic [7:0] q_val[$];
  string      q_name[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has come due
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      checks++;
      if (q_cyc[0] < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d), required %02h",
                 q_name[0], q_cyc[0], cyc, q_val[0]);
      end else if (io_out !== q_val[0]) begin
        errors++;
        $display("FAIL %s: io_out=%02h required %02h (cycle %0d)", q_name[0], io_out, q_val[0], cyc);
      end
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
  end

  task automatic bus(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    addr_b  = a;
    din_b   = d;
    drv_cyc = cyc;
  endtask

  // Expect io_out == v at 'off' cycles after the most recent bus drive
  task automatic expect_out(input string n, input int off, input logic [7:0] v);
    q_cyc.push_back(drv_cyc + off);
    q_val.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic set_data(input logic [7:0] b);
    bus(A_LOW, b[3:0]);
    bus(A_HIGH, b[7:4]);
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] v);
    set_data(a);
    bus(A_CMD, C_LATCH);
    set_data(v);
    bus(A_CMD, C_WRITE);
  endtask

  task automatic read_check(input string n, input logic [7:0] a, input logic [7:0] e);
    set_data(a);
    bus(A_CMD, C_LATCH);
    bus(A_CMD, C_READ);
    expect_out(n, 1, e);
    bus(A_IDLE, 4'h0);
  endtask

  task automatic load_block(input logic [79:0] key, input logic [63:0] pt);
    for (int i = 0; i < 10; i++) write_byte(8'(8'h10 + i), key[8*i +: 8]);
    for (int i = 0; i < 8; i++) write_byte(8'(i), pt[8*i +: 8]);
    bus(A_IDLE, 4'h0);
  endtask

  task automatic run_check(input string n, input logic [63:0] ct, input bit disturb);
    int st;
    bus(A_CMD, C_START);
    st = drv_cyc;
    expect_out({n, "_busy"}, 1, 8'h00);
    expect_out({n, "_busy_last"}, 32, 8'h00);
    expect_out({n, "_ready"}, 33, 8'h01);
    bus(A_IDLE, 4'h0);
    if (disturb) begin
      write_byte(8'h00, 8'h5A);
      bus(A_CMD, C_START);
      bus(A_IDLE, 4'h0);
    end
    while (cyc < st + 34) bus(A_IDLE, 4'h0);
    for (int i = 0; i < 8; i++) read_check($sformatf("%s_ct%0d", n, i), 8'(i), ct[8*i +: 8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tr;
`ifdef FOSFOR_TEST_REG_EN
    exp_tr = 8'hA5;
`else
    exp_tr = 8'h00;
`endif

    // Reset and idle status
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus(A_IDLE, 4'h0);
    bus(A_IDLE, 4'h0);
    expect_out("reset_status", 1, 8'h01);
    bus(A_IDLE, 4'h0);

    // Known-answer vectors
    load_block(80'h0, 64'h0);
    run_check("kat_zero", 64'h5579C1387B228445, 1'b0);
    load_block({80{1'b1}}, 64'h0);
    run_check("kat_keyF", 64'hE72C46C0F5945049, 1'b0);
    load_block(80'h0, {64{1'b1}});
    run_check("kat_ptF", 64'hA112FFC72F68417B, 1'b0);

    // Write and START while busy are ignored
    load_block(80'h0, 64'h0);
    run_check("busy_ignore", 64'h5579C1387B228445, 1'b1);

    // Key registers remain readable and unchanged after a run
    read_check("key_byte9", 8'h19, 8'h00);

    // Read data stays visible across a LOW strobe, LATCH returns to status
    read_check("vis_read", 8'h07, 8'h55);
    bus(A_LOW, 4'hF);
    expect_out("vis_low", 1, 8'h55);
    bus(A_CMD, C_LATCH);
    expect_out("latch_status", 1, 8'h01);
    bus(A_IDLE, 4'h0);

    // Scratch register and unmapped addresses
    write_byte(8'h08, 8'hA5);
    read_check("test_reg", 8'h08, exp_tr);
    write_byte(8'h20, 8'h77);
    read_check("unmapped_20", 8'h20, 8'h00);
    read_check("unmapped_1a", 8'h1A, 8'h00);

    // Reset in the middle of a run
    load_block({80{1'b1}}, {64{1'b1}});
    bus(A_CMD, C_START);
    repeat (5) bus(A_IDLE, 4'h0);
    rst_n = 1'b0;
    expect_out("rst_mid_status", 1, 8'h01);
    bus(A_IDLE, 4'h0);
    rst_n = 1'b1;
    bus(A_IDLE, 4'h0);
    expect_out("rst_release_status", 1, 8'h01);
    bus(A_IDLE, 4'h0);
    read_check("rst_state0", 8'h00, 8'h00);
    read_check("rst_key0", 8'h10, 8'h00);

    repeat (3) bus(A_IDLE, 4'h0);
    while (q_cyc.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked, required %02h", q_name[0], q_val[0]);
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
